// File: rtl/chal_input_net_seq.sv
// Sequential challenge input network: one master challenge in, K rotated and transformed channel challenges out.
// Optional macro CHAL_PARITY_EN adds out_par, the XOR-reduce of out_chal.
//
// state | meaning
// IDLE  | ready for a master challenge, no channel output valid
// ISSUE | presenting channel out_ch_q, advancing on each output handshake
module chal_input_net_seq #(
   parameter int N     = 64,
   parameter int K     = 4,
   parameter int SHIFT = 1,
   localparam int CW   = (K > 1) ? $clog2(K) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_chal,
   input  logic [1:0]    mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_chal,
   output logic [CW-1:0] out_ch,
`ifdef CHAL_PARITY_EN
   output logic          out_par,
`endif
   output logic          out_last
);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  x_q, x_d;
   logic [1:0]    m_q, m_d;
   logic          out_valid_q, out_valid_d;
   logic [N-1:0]  out_chal_q, out_chal_d;
   logic [CW-1:0] out_ch_q, out_ch_d;
   logic          out_last_q, out_last_d;
   logic [31:0]   amt_next;

   function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input logic [31:0] amt);
      // amt is already reduced below N; a shift by N yields zero, covering amt == 0
      return (v << amt) | (v >> (32'(N) - amt));
   endfunction

   function automatic logic [N-1:0] xform(input logic [N-1:0] v, input logic [1:0] m);
      logic [N-1:0] r;
      r = '0;
      case (m)
         2'd0:    r = v;
         2'd1:    r = v ^ (v >> 1);
         2'd2:    for (int s = 0; s < N; s++) r = r ^ (v >> s);
         default: r = ~v;
      endcase
      return r;
   endfunction

   assign amt_next = ((32'(out_ch_q) + 32'd1) * 32'(SHIFT)) % 32'(N);

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      m_d         = m_q;
      out_valid_d = out_valid_q;
      out_chal_d  = out_chal_q;
      out_ch_d    = out_ch_q;
      out_last_d  = out_last_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d         = in_chal;
               m_d         = mode;
               state_d     = ISSUE;
               out_valid_d = 1'b1;
               out_ch_d    = '0;
               out_chal_d  = xform(in_chal, mode);
               out_last_d  = (K == 1);
            end
         end
         default: begin
            if (out_ready) begin
               if (out_last_q) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end else begin
                  out_ch_d   = out_ch_q + CW'(1);
                  out_chal_d = xform(rotl(x_q, amt_next), m_q);
                  out_last_d = (out_ch_d == CW'(K - 1));
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         m_q         <= '0;
         out_valid_q <= 1'b0;
         out_chal_q  <= '0;
         out_ch_q    <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         m_q         <= m_d;
         out_valid_q <= out_valid_d;
         out_chal_q  <= out_chal_d;
         out_ch_q    <= out_ch_d;
         out_last_q  <= out_last_d;
      end
   end

`ifdef CHAL_PARITY_EN
   logic out_par_q;

   always_ff @(posedge clk) begin
      if (rst) out_par_q <= 1'b0;
      else     out_par_q <= ^out_chal_d;
   end

   assign out_par = out_par_q;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign out_chal  = out_chal_q;
   assign out_ch    = out_ch_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_chal_input_net_seq.sv
// Bench for chal_input_net_seq: vector table, hand sequences and random bursts against a bit-level model.
// Also exercises K=1 and SHIFT=9 instances; checks out_par when CHAL_PARITY_EN is defined.
module tb_chal_input_net_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_chal = 8'h00;
   logic [1:0] mode = 2'd0;
   logic       out_ready = 1'b0;
   logic       in_ready, out_valid, out_last;
   logic [7:0] out_chal;
   logic [1:0] out_ch;

   logic       k1_in_valid = 1'b0, k1_out_ready = 1'b1;
   logic       k1_in_ready, k1_out_valid, k1_out_last;
   logic [7:0] k1_out_chal;
   logic [0:0] k1_out_ch;

   logic       s9_in_valid = 1'b0, s9_out_ready = 1'b1;
   logic       s9_in_ready, s9_out_valid, s9_out_last;
   logic [7:0] s9_out_chal;
   logic [1:0] s9_out_ch;

`ifdef CHAL_PARITY_EN
   logic out_par, k1_out_par, s9_out_par;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   chal_input_net_seq #(.N(8), .K(4), .SHIFT(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_chal(in_chal), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
      .out_chal(out_chal), .out_ch(out_ch),
`ifdef CHAL_PARITY_EN
      .out_par(out_par),
`endif
      .out_last(out_last));

   chal_input_net_seq #(.N(8), .K(1), .SHIFT(9)) dut_k1 (
      .clk(clk), .rst(rst), .in_valid(k1_in_valid), .in_ready(k1_in_ready),
      .in_chal(in_chal), .mode(mode), .out_valid(k1_out_valid), .out_ready(k1_out_ready),
      .out_chal(k1_out_chal), .out_ch(k1_out_ch),
`ifdef CHAL_PARITY_EN
      .out_par(k1_out_par),
`endif
      .out_last(k1_out_last));

   chal_input_net_seq #(.N(8), .K(4), .SHIFT(9)) dut_s9 (
      .clk(clk), .rst(rst), .in_valid(s9_in_valid), .in_ready(s9_in_ready),
      .in_chal(in_chal), .mode(mode), .out_valid(s9_out_valid), .out_ready(s9_out_ready),
      .out_chal(s9_out_chal), .out_ch(s9_out_ch),
`ifdef CHAL_PARITY_EN
      .out_par(s9_out_par),
`endif
      .out_last(s9_out_last));

   // Reference: bit j of the rotated word comes from bit (j - amount) mod 8, then the transform rule per bit.
   function automatic logic [7:0] ref_chal(input logic [7:0] x, input int m, input int ch, input int sh);
      logic [7:0] v, o;
      logic       p;
      int         a;
      a = (ch * sh) % 8;
      for (int j = 0; j < 8; j++) v[3'(j)] = x[3'((j - a + 8) % 8)];
      o = v;
      for (int j = 0; j < 8; j++) begin
         case (m)
            1: o[3'(j)] = (j == 7) ? v[7] : (v[3'(j)] ^ v[3'(j + 1)]);
            2: begin
               p = 1'b0;
               for (int k = j; k < 8; k++) p = p ^ v[3'(k)];
               o[3'(j)] = p;
            end
            3: o[3'(j)] = ~v[3'(j)];
            default: o[3'(j)] = v[3'(j)];
         endcase
      end
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_par(input string name, input logic [7:0] exp_chal);
`ifdef CHAL_PARITY_EN
      chk(name, 32'(out_par), 32'(^exp_chal));
`else
      if (exp_chal === 8'hxx) $display("unreachable %s", name);
`endif
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic burst(input logic [7:0] chal, input logic [1:0] m, input bit rand_ready,
                        input bit use_exp, input logic [7:0] exp0);
      int ch, cyc;
      logic [7:0] e;
      ch  = 0;
      cyc = 0;
      in_valid = 1'b1;
      in_chal  = chal;
      mode     = m;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_chal  = ~chal;
      mode     = ~m;
      while (ch < 4 && cyc < 200) begin
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         e = ref_chal(chal, int'(m), ch, 1);
         chk("burst_valid", 32'(out_valid), 32'd1);
         chk("burst_in_ready", 32'(in_ready), 32'd0);
         chk("burst_chal", 32'(out_chal), 32'(e));
         chk("burst_ch", 32'(out_ch), 32'(ch));
         chk("burst_last", 32'(out_last), 32'(ch == 3));
         chk_par("burst_par", e);
         if (use_exp && ch == 0) chk("table_ch0", 32'(out_chal), 32'(exp0));
         @(posedge clk); #1;
         if (out_ready) ch++;
         cyc++;
      end
      if (ch < 4) chk("burst_timeout", 32'(ch), 32'd4);
      @(negedge clk);
      chk("burst_end_valid", 32'(out_valid), 32'd0);
      chk("burst_end_ready", 32'(in_ready), 32'd1);
   endtask

   typedef struct {
      logic [7:0] chal;
      logic [1:0] mode;
      logic [7:0] exp0;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h6E, 2'd0, 8'h6E};
      vecs[1] = '{8'h6E, 2'd1, 8'h59};
      vecs[2] = '{8'h6E, 2'd2, 8'h4B};
      vecs[3] = '{8'h6E, 2'd3, 8'h91};
      vecs[4] = '{8'h01, 2'd0, 8'h01};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_ch", 32'(out_ch), 32'd0);
      chk("rst_chal", 32'(out_chal), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk_par("rst_par", 8'h00);

      for (int i = 0; i < 5; i++) burst(vecs[i].chal, vecs[i].mode, 1'b0, 1'b1, vecs[i].exp0);

      // Stall on ch1, then complete the burst with explicit values.
      in_valid = 1'b1; in_chal = 8'h6E; mode = 2'd0; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("stall_ch0", 32'(out_chal), 32'h6E);
      @(posedge clk); #1 out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_hold_chal", 32'(out_chal), 32'hDC);
         chk("stall_hold_ch", 32'(out_ch), 32'd1);
         chk("stall_hold_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_adv_chal", 32'(out_chal), 32'hB9);
      chk("stall_adv_ch", 32'(out_ch), 32'd2);
      chk("stall_adv_last", 32'(out_last), 32'd0);
      @(negedge clk);
      chk("ch3_chal", 32'(out_chal), 32'h73);
      chk("ch3_last", 32'(out_last), 32'd1);
      @(negedge clk);
      chk("stall_end_valid", 32'(out_valid), 32'd0);
      chk("stall_end_ready", 32'(in_ready), 32'd1);

      // in_valid with 8'hFF during ISSUE is ignored until IDLE.
      in_valid = 1'b1; in_chal = 8'h6E; mode = 2'd0; out_ready = 1'b1;
      @(posedge clk); #1 in_chal = 8'hFF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("ign_in_ready", 32'(in_ready), 32'd0);
         chk("ign_chal", 32'(out_chal), 32'(ref_chal(8'h6E, 0, c, 1)));
         chk("ign_ch", 32'(out_ch), 32'(c));
      end
      @(negedge clk);
      chk("ign_idle_ready", 32'(in_ready), 32'd1);
      chk("ign_idle_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("ign_ff_accepted", 32'(out_chal), 32'hFF);
      chk("ign_ff_ch", 32'(out_ch), 32'd0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("ign_ff_done", 32'(out_valid), 32'd0);

      // Reset while ch2 is presented.
      in_valid = 1'b1; in_chal = 8'h6E; mode = 2'd0; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("mid_ch2", 32'(out_chal), 32'hB9);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_ch", 32'(out_ch), 32'd0);
      @(negedge clk);
      chk("mid_rst_no_partial", 32'(out_valid), 32'd0);
      burst(8'h01, 2'd0, 1'b0, 1'b1, 8'h01);

      // K=1 and SHIFT=9 instances.
      in_chal = 8'h6E; mode = 2'd0;
      k1_in_valid = 1'b1; s9_in_valid = 1'b1;
      @(posedge clk); #1 k1_in_valid = 1'b0; s9_in_valid = 1'b0;
      @(negedge clk);
      chk("k1_valid", 32'(k1_out_valid), 32'd1);
      chk("k1_chal", 32'(k1_out_chal), 32'h6E);
      chk("k1_last", 32'(k1_out_last), 32'd1);
      chk("k1_ch", 32'(k1_out_ch), 32'd0);
      chk("s9_ch0", 32'(s9_out_chal), 32'h6E);
      @(negedge clk);
      chk("k1_done_valid", 32'(k1_out_valid), 32'd0);
      chk("k1_done_ready", 32'(k1_in_ready), 32'd1);
      chk("s9_ch1", 32'(s9_out_chal), 32'hDC);
      for (int c = 2; c < 4; c++) begin
         @(negedge clk);
         chk("s9_chal", 32'(s9_out_chal), 32'(ref_chal(8'h6E, 0, c, 9)));
         chk("s9_last", 32'(s9_out_last), 32'(c == 3));
      end
      @(negedge clk);
      chk("s9_done", 32'(s9_out_valid), 32'd0);

      // Random bursts with random backpressure.
      for (int r = 0; r < 25; r++) burst(8'($urandom), 2'($urandom_range(0, 3)), 1'b1, 1'b0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chal_input_net_seq.md
Name: chal_input_net_seq

Overview:
- Parametrised, sequential successor to the combinational challenge input network in the XOR/LS-PUF datapath.
- Accepts one N-bit master challenge per valid/ready handshake and issues K per-channel transformed challenges, one per output handshake, to the K arbiter-PUF chains.
- Each channel's challenge is a rotation of the master challenge followed by a run-time selectable transform.

Parameters:
- N, 64, challenge width in bits (N >= 2).
- K, 4, number of PUF channels, i.e. challenges issued per accepted master challenge (K >= 1).
- SHIFT, 1, per-channel left-rotation step in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  master challenge valid.
- in_ready  out  1  block can accept a master challenge.
- in_chal  in  N  master challenge.
- mode  in  2  transform select; sampled with in_chal.
- out_valid  out  1  channel challenge valid.
- out_ready  in  1  downstream accepts the channel challenge.
- out_chal  out  N  transformed channel challenge.
- out_ch  out  CW  channel index; CW = (K>1) ? clog2(K) : 1.
- out_last  out  1  high with the final channel (out_ch == K-1).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_chal=0, out_ch=0, out_last=0. in_ready=1 from the first cycle after reset.
- FSM with two states, IDLE and ISSUE. in_ready = (state==IDLE), decoded combinationally from the state register.
- IDLE:
  - On in_valid&&in_ready, latch in_chal into x_r and mode into m_r.
  - Next cycle: state=ISSUE, out_valid=1, out_ch=0, out_chal=T(rotl(x,0)).
  - Latency from the accept edge to out_valid is 1 cycle.
- ISSUE, per-channel rule:
  - Channel i drives out_chal = T(rotl(x_r, (i*SHIFT) mod N), m_r).
  - out_chal, out_ch and out_last are registered and held stable while out_valid && !out_ready.
  - On out_valid&&out_ready with i<K-1: the next cycle loads channel i+1 and out_valid stays 1. Throughput is one channel per cycle with out_ready held high.
  - On out_valid&&out_ready with i==K-1: the next cycle sets out_valid=0 and state=IDLE.
  - K=1: the first handshake ends the burst.
- Transforms T(v, m), bit j in 0..N-1:
  - m=0: pass, out[j] = v[j].
  - m=1: adjacent XOR, out = v ^ (v>>1), so out[N-1] = v[N-1].
  - m=2: suffix parity (phi), out[j] = XOR of v[N-1:j].
  - m=3: invert, out = ~v.
- Inputs ignored outside IDLE:
  - in_valid while in ISSUE is ignored, since in_ready=0. No queuing.
  - Changes to in_chal or mode during ISSUE have no effect.
- Rotation wrap-around: the amount is computed mod N with full-width arithmetic. i*SHIFT >= N wraps; no overflow for K*SHIFT < 2^32.
- Reset mid-burst: the next cycle is IDLE with out_valid=0. The remaining channels are discarded, with no partial output after reset.
- No combinational path from in_* to out_*. Only in_ready depends on state.

Optional Feature:
- Macro: CHAL_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit) = XOR-reduce of out_chal.
  - out_par is registered in the same cycle as out_chal and obeys the same hold rule.
  - Reset value is 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- N=8, K=4, SHIFT=1, mode=0, in_chal=8'h6E, out_ready=1 → accept, then 4 consecutive cycles with out_ch 0..3 and out_chal 6E, DC, B9, 73. out_last only on 73. Next cycle out_valid=0 and in_ready=1.
- Same challenge, mode=1 → ch0 out_chal=8'h59. Mode=2 → ch0 8'h4B. Mode=3 → ch0 8'h91. With CHAL_PARITY_EN, out_par=0 for 8'h59.
- Mode=0, out_ready held low for 3 cycles while ch1 is presented → out_chal stays 8'hDC and out_ch stays 1. On out_ready=1 it advances to ch2 (8'hB9).
- in_valid=1 with in_chal=8'hFF during ISSUE → in_ready=0, the burst continues with 6E-derived values, and 8'hFF is not accepted until IDLE.
- rst asserted for 1 cycle while ch2 is presented → next cycle out_valid=0, in_ready=1, out_ch=0. A fresh in_chal=8'h01 with mode=0 then gives 01, 02, 04, 08.
- K=1 and N=8, SHIFT=9: ch0 → one output (8'h6E) with out_last=1, then IDLE. K=4 → ch1 rotation of 9 mod 8 = 1 → 8'hDC.
